// File: rtl/emoji_pkg.sv
// Shared types and defaults for the emoji overlay compositing stage.
// The pipeline stage struct carries everything that must stay aligned with the ROM read.
package emoji_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t KEY_DEFAULT = 16'hF81F;
  localparam int      W_DEFAULT   = 64;
  localparam int      H_DEFAULT   = 64;
  localparam int      NUM_DEFAULT = 6;

  typedef struct packed {
    logic    hit;
    rgb565_t pix;
    logic    de;
    logic    hsync;
    logic    vsync;
  } stage_t;

  localparam stage_t STAGE_RESET = '{hit: 1'b0, pix: 16'h0000, de: 1'b0, hsync: 1'b0, vsync: 1'b0};

endpackage

// File: rtl/emoji_window_hit.sv
// Combinational window test: offset of the current pixel from the sprite origin,
// inside/outside decision and texel coordinates after de-magnification.
module emoji_window_hit #(
  parameter int W          = 64,
  parameter int H          = 64,
  parameter int SCALE_LOG2 = 0,
  parameter int XW         = 10
) (
  input  logic          en,
  input  logic          de,
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] y,
  input  logic [XW-1:0] pos_x,
  input  logic [XW-1:0] pos_y,
  output logic          hit,
  output logic [XW-1:0] tx,
  output logic [XW-1:0] ty
);

  localparam logic [31:0] WS = 32'(W << SCALE_LOG2);
  localparam logic [31:0] HS = 32'(H << SCALE_LOG2);

  logic signed [XW:0] dx;
  logic signed [XW:0] dy;
  logic [XW-1:0]      dx_m;
  logic [XW-1:0]      dy_m;
  logic               in_x;
  logic               in_y;

  // One extra sign bit keeps origins near the far edge from wrapping onto x/y = 0.
  assign dx   = $signed({1'b0, x}) - $signed({1'b0, pos_x});
  assign dy   = $signed({1'b0, y}) - $signed({1'b0, pos_y});
  assign dx_m = dx[XW-1:0];
  assign dy_m = dy[XW-1:0];

  assign in_x = ~dx[XW] && (32'(dx_m) < WS);
  assign in_y = ~dy[XW] && (32'(dy_m) < HS);

  assign hit = en & de & in_x & in_y;
  assign tx  = dx_m >> SCALE_LOG2;
  assign ty  = dy_m >> SCALE_LOG2;

endmodule

// File: rtl/emoji_overlay.sv
// Composites an emoji sprite from an external registered ROM over the camera stream.
// Sprite controls are shadow-latched on vsync rising edge; every output lags its input by 3 clks.
module emoji_overlay
  import emoji_pkg::*;
#(
  parameter int          W          = W_DEFAULT,
  parameter int          H          = H_DEFAULT,
  parameter int          NUM        = NUM_DEFAULT,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [15:0] KEY        = KEY_DEFAULT,
  parameter int          XW         = 10,
  parameter int          AW         = $clog2(W * H * NUM),
  parameter int          SW         = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] x_in,
  input  logic [XW-1:0] y_in,
  input  logic          de_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [15:0]   pix_in,
  input  logic          en,
  input  logic [SW-1:0] sel,
  input  logic [XW-1:0] pos_x,
  input  logic [XW-1:0] pos_y,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [15:0]   pix_out
);

  logic          vs_q;
  logic          frame_latch;
  logic          sel_legal;
  logic          en_s;
  logic [SW-1:0] sel_s;
  logic [XW-1:0] pos_x_s;
  logic [XW-1:0] pos_y_s;

  logic          hit;
  logic [XW-1:0] tx;
  logic [XW-1:0] ty;
  logic [AW-1:0] addr_n;

  stage_t        d1;
  stage_t        d2;
  logic          show_rom;

  assign frame_latch = vsync_in & ~vs_q;
  assign sel_legal   = 32'(sel) < 32'(NUM);

  // Shadow copies of the sprite controls, refreshed once per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q    <= 1'b0;
      en_s    <= 1'b0;
      sel_s   <= '0;
      pos_x_s <= '0;
      pos_y_s <= '0;
    end else begin
      vs_q <= vsync_in;
      if (frame_latch) begin
        en_s    <= en & sel_legal;
        sel_s   <= sel;
        pos_x_s <= pos_x;
        pos_y_s <= pos_y;
      end
    end
  end

  emoji_window_hit #(
    .W         (W),
    .H         (H),
    .SCALE_LOG2(SCALE_LOG2),
    .XW        (XW)
  ) u_hit (
    .en   (en_s),
    .de   (de_in),
    .x    (x_in),
    .y    (y_in),
    .pos_x(pos_x_s),
    .pos_y(pos_y_s),
    .hit  (hit),
    .tx   (tx),
    .ty   (ty)
  );

  assign addr_n = AW'(sel_s) * AW'(W * H) + AW'(ty) * AW'(W) + AW'(tx);

  // Stage 1 issues the ROM read; the address only moves on a hit to avoid needless toggling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      d1       <= STAGE_RESET;
    end else begin
      if (hit) rom_addr <= addr_n;
      d1.hit   <= hit;
      d1.pix   <= pix_in;
      d1.de    <= de_in;
      d1.hsync <= hsync_in;
      d1.vsync <= vsync_in;
    end
  end

  // Stage 2 waits out the ROM's own output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) d2 <= STAGE_RESET;
    else       d2 <= d1;
  end

  assign show_rom = d2.hit && (rom_data != KEY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_out   <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      pix_out   <= show_rom ? rom_data : d2.pix;
      de_out    <= d2.de;
      hsync_out <= d2.hsync;
      vsync_out <= d2.vsync;
    end
  end

endmodule
